biquad_bank_sequencer: RTL and testbench

BIQUAD_BANK_SEQUENCER -- requirements
Module: biquad_bank_sequencer

---
 rtl/biquad_bank_sequencer.sv | 156 +++++++++++++++
 tb/tb_biquad_bank_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_bank_sequencer.sv
// Time-multiplexes one double_biquad over NUM_BANDS filter bands.
// Holds the shared x history and per-band i/y history, and sequences one band at a time.

module biquad_band_hist (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        clear_in,
    input  logic        wr_in,
    input  logic [31:0] i_in,
    input  logic [31:0] y_in,
    output logic [31:0] i_n1,
    output logic [31:0] i_n2,
    output logic [31:0] y_n1,
    output logic [31:0] y_n2
);
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            i_n1 <= '0;
            i_n2 <= '0;
            y_n1 <= '0;
            y_n2 <= '0;
        end else if (clear_in) begin
            i_n1 <= '0;
            i_n2 <= '0;
            y_n1 <= '0;
            y_n2 <= '0;
        end else if (wr_in) begin
            i_n2 <= i_n1;
            i_n1 <= i_in;
            y_n2 <= y_n1;
            y_n1 <= y_in;
        end
    end
endmodule

module biquad_bank_sequencer #(
    parameter int NUM_BANDS = 4,
    parameter int BW        = $clog2(NUM_BANDS)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic signed [31:0]   sample_in,
    input  logic                 sample_valid_in,
    output logic                 ready_out,
    input  logic                 clear_in,
    output logic [BW-1:0]        band_out,
    output logic                 bq_valid_out,
    output logic signed [31:0]   bq_x_n,
    output logic signed [31:0]   bq_x_n1,
    output logic signed [31:0]   bq_x_n2,
    output logic signed [31:0]   bq_i_n1,
    output logic signed [31:0]   bq_i_n2,
    output logic signed [31:0]   bq_y_n1,
    output logic signed [31:0]   bq_y_n2,
    input  logic signed [31:0]   bq_i_n,
    input  logic signed [31:0]   bq_y_n,
    input  logic                 bq_valid_in,
    output logic signed [31:0]   result_y_out,
    output logic [BW-1:0]        result_band_out,
    output logic                 result_valid_out,
    output logic                 done_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [BW-1:0] LAST_BAND = BW'(NUM_BANDS - 1);

    state_t      state;
    logic [31:0] x_cur, x_n1, x_n2;
    logic        band_wr, hist_clr;

    logic [NUM_BANDS-1:0][31:0] hi1, hi2, hy1, hy2;

    assign band_wr  = (state == WAIT) && bq_valid_in;
    assign hist_clr = (state == IDLE) && clear_in;

    // Held low through reset so nothing upstream sees a ready before release.
    assign ready_out = (state == IDLE) && !clear_in && rst_in;

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        biquad_band_hist u_hist (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .clear_in (hist_clr),
            .wr_in    (band_wr && (band_out == BW'(b))),
            .i_in     (bq_i_n),
            .y_in     (bq_y_n),
            .i_n1     (hi1[b]),
            .i_n2     (hi2[b]),
            .y_n1     (hy1[b]),
            .y_n2     (hy2[b])
        );
    end

    // Data outputs are pure register views, so they stay put from ISSUE through WAIT.
    assign bq_x_n  = x_cur;
    assign bq_x_n1 = x_n1;
    assign bq_x_n2 = x_n2;
    assign bq_i_n1 = hi1[band_out];
    assign bq_i_n2 = hi2[band_out];
    assign bq_y_n1 = hy1[band_out];
    assign bq_y_n2 = hy2[band_out];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            x_cur            <= '0;
            x_n1             <= '0;
            x_n2             <= '0;
            band_out         <= '0;
            bq_valid_out     <= 1'b0;
            result_y_out     <= '0;
            result_band_out  <= '0;
            result_valid_out <= 1'b0;
            done_out         <= 1'b0;
        end else begin
            bq_valid_out     <= 1'b0;
            result_valid_out <= 1'b0;
            done_out         <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_in) begin
                        x_n1 <= '0;
                        x_n2 <= '0;
                    end else if (sample_valid_in) begin
                        x_cur        <= sample_in;
                        band_out     <= '0;
                        bq_valid_out <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bq_valid_in) begin
                        result_y_out     <= bq_y_n;
                        result_band_out  <= band_out;
                        result_valid_out <= 1'b1;
                        if (band_out == LAST_BAND) begin
                            done_out <= 1'b1;
                            state    <= DONE;
                        end else begin
                            band_out     <= band_out + 1'b1;
                            bq_valid_out <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    x_n2  <= x_n1;
                    x_n1  <= x_cur;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_biquad_bank_sequencer.sv
// Scoreboard bench for biquad_bank_sequencer with a two-cycle double_biquad model.
// Directed samples push expected issues/results; a negedge monitor pops and compares.

module tb_biquad_bank_sequencer;
    localparam int NB = 4;
    localparam int BW = 2;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic signed [31:0]  sample_in;
    logic                sample_valid_in;
    logic                ready_out;
    logic                clear_in;
    logic [BW-1:0]       band_out;
    logic                bq_valid_out;
    logic signed [31:0]  bq_x_n, bq_x_n1, bq_x_n2;
    logic signed [31:0]  bq_i_n1, bq_i_n2, bq_y_n1, bq_y_n2;
    logic signed [31:0]  bq_i_n, bq_y_n;
    logic                bq_valid_in;
    logic signed [31:0]  result_y_out;
    logic [BW-1:0]       result_band_out;
    logic                result_valid_out;
    logic                done_out;

    logic        m_valid = 1'b0, t_valid = 1'b0;
    logic [31:0] m_i = '0, m_y = '0, t_i = '0, t_y = '0;

    assign bq_valid_in = m_valid | t_valid;
    assign bq_i_n      = t_valid ? t_i : m_i;
    assign bq_y_n      = t_valid ? t_y : m_y;

    always #5 clk_in = ~clk_in;

    biquad_bank_sequencer #(.NUM_BANDS(NB)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .sample_in(sample_in), .sample_valid_in(sample_valid_in), .ready_out(ready_out),
        .clear_in(clear_in), .band_out(band_out), .bq_valid_out(bq_valid_out),
        .bq_x_n(bq_x_n), .bq_x_n1(bq_x_n1), .bq_x_n2(bq_x_n2),
        .bq_i_n1(bq_i_n1), .bq_i_n2(bq_i_n2), .bq_y_n1(bq_y_n1), .bq_y_n2(bq_y_n2),
        .bq_i_n(bq_i_n), .bq_y_n(bq_y_n), .bq_valid_in(bq_valid_in),
        .result_y_out(result_y_out), .result_band_out(result_band_out),
        .result_valid_out(result_valid_out), .done_out(done_out)
    );

    typedef struct {
        int          band;
        logic [31:0] x, x1, x2, i1, i2, y1, y2;
    } iss_t;
    typedef struct {
        int          band;
        logic [31:0] y;
    } res_t;

    iss_t exp_iss[$];
    res_t exp_res[$];

    int n_vec = 0, n_err = 0;
    int cyc = 0, acc_cyc = 0, done_cnt = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
        end
    endtask

    // h = how many completed samples of i/y history each band holds (0,1,2)
    task automatic push_sample(input logic [31:0] x, input logic [31:0] x1, input logic [31:0] x2,
                               input int h, input int n_iss, input int n_res);
        for (int b = 0; b < n_iss; b++) begin
            iss_t e;
            e.band = b; e.x = x; e.x1 = x1; e.x2 = x2;
            e.i1 = (h >= 1) ? 32'(10 * b + 1)  : 32'd0;
            e.y1 = (h >= 1) ? 32'(100 * b + 2) : 32'd0;
            e.i2 = (h >= 2) ? 32'(10 * b + 1)  : 32'd0;
            e.y2 = (h >= 2) ? 32'(100 * b + 2) : 32'd0;
            exp_iss.push_back(e);
        end
        for (int b = 0; b < n_res; b++) begin
            res_t r;
            r.band = b; r.y = 32'(100 * b + 2);
            exp_res.push_back(r);
        end
    endtask

    task automatic send(input logic [31:0] v);
        int n = 0;
        @(negedge clk_in);
        while (!ready_out && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk("send_ready", 32'(ready_out), 32'd1);
        acc_cyc         = cyc;
        sample_in       = v;
        sample_valid_in = 1'b1;
        @(posedge clk_in);
        #1 sample_valid_in = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        chk("done_count", 32'(done_cnt), 32'(target));
    endtask

    // double_biquad model: answer arrives two cycles after the start pulse
    always begin : model
        int mb;
        @(negedge clk_in);
        if (bq_valid_out && rst_in) begin
            mb = int'(band_out);
            @(posedge clk_in);
            @(posedge clk_in);
            #1;
            m_valid = 1'b1;
            m_i     = 32'(10 * mb + 1);
            m_y     = 32'(100 * mb + 2);
            @(posedge clk_in);
            #1 m_valid = 1'b0;
        end
    end

    always @(negedge clk_in) begin : monitor
        iss_t        e;
        res_t        r;
        logic [1:0]  lat_band;
        logic [31:0] lat_x, lat_i1;
        if (rst_in) begin
            if (bq_valid_out) begin
                lat_band = band_out; lat_x = bq_x_n; lat_i1 = bq_i_n1;
                if (exp_iss.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_issue: got band %0d expected none", band_out);
                end else begin
                    e = exp_iss.pop_front();
                    chk("iss_band", 32'(band_out), 32'(e.band));
                    chk("iss_x_n",  bq_x_n,  e.x);
                    chk("iss_x_n1", bq_x_n1, e.x1);
                    chk("iss_x_n2", bq_x_n2, e.x2);
                    chk("iss_i_n1", bq_i_n1, e.i1);
                    chk("iss_i_n2", bq_i_n2, e.i2);
                    chk("iss_y_n1", bq_y_n1, e.y1);
                    chk("iss_y_n2", bq_y_n2, e.y2);
                end
            end
            if (m_valid) begin
                chk("hold_band", 32'(band_out), 32'(lat_band));
                chk("hold_x_n",  bq_x_n,  lat_x);
                chk("hold_i_n1", bq_i_n1, lat_i1);
            end
            if (result_valid_out) begin
                if (exp_res.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_result: got %0d expected none", result_y_out);
                end else begin
                    r = exp_res.pop_front();
                    chk("res_band", 32'(result_band_out), 32'(r.band));
                    chk("res_y",    result_y_out,         r.y);
                end
            end
            if (done_out) begin
                done_cnt++;
                chk("done_latency", 32'(cyc - acc_cyc), 32'(3 * NB + 1));
            end
        end
    end

    initial begin
        int  hi;
        logic seen;
        rst_in = 1'b0; sample_in = '0; sample_valid_in = 1'b0; clear_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("rst_ready",    32'(ready_out),        32'd0);
        chk("rst_band",     32'(band_out),         32'd0);
        chk("rst_bq_valid", 32'(bq_valid_out),     32'd0);
        chk("rst_bq_x_n",   bq_x_n,                32'd0);
        chk("rst_res_vld",  32'(result_valid_out), 32'd0);
        chk("rst_done",     32'(done_out),         32'd0);
        rst_in = 1'b1;

        push_sample(1000, 0, 0, 0, NB, NB);
        send(1000);
        wait_done(1);

        push_sample(2000, 1000, 0, 1, NB, NB);
        send(2000);
        wait_done(2);

        // valid held high across two samples
        push_sample(3000, 2000, 1000, 2, NB, NB);
        push_sample(4000, 3000, 2000, 2, NB, NB);
        @(negedge clk_in);
        acc_cyc = cyc; sample_in = 3000; sample_valid_in = 1'b1;
        chk("hold_accept_ready", 32'(ready_out), 32'd1);
        @(posedge clk_in);
        #1 sample_in = 4000;
        hi = 0; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_in);
            if (done_out) seen = 1'b1;
            else if (ready_out) hi++;
        end
        chk("busy_done_seen", 32'(seen), 32'd1);
        chk("busy_ready_low", 32'(hi),   32'd0);
        @(negedge clk_in);
        chk("reaccept_ready", 32'(ready_out), 32'd1);
        acc_cyc = cyc;
        @(posedge clk_in);
        #1 sample_valid_in = 1'b0;
        wait_done(4);

        // clear and sample offered together
        @(negedge clk_in);
        clear_in = 1'b1; sample_valid_in = 1'b1; sample_in = 5000;
        #1 chk("clear_ready", 32'(ready_out), 32'd0);
        @(posedge clk_in);
        #1 begin clear_in = 1'b0; sample_valid_in = 1'b0; end
        @(negedge clk_in);
        chk("clear_no_issue", 32'(bq_valid_out), 32'd0);
        chk("clear_ready_back", 32'(ready_out), 32'd1);
        push_sample(5000, 0, 0, 0, NB, NB);
        send(5000);
        wait_done(5);

        // stray bq_valid_in in IDLE, then in ISSUE
        @(negedge clk_in);
        t_valid = 1'b1; t_i = 777; t_y = 888;
        @(posedge clk_in);
        #1 t_valid = 1'b0;
        @(negedge clk_in);
        chk("idle_pulse_no_res", 32'(result_valid_out), 32'd0);
        push_sample(6000, 5000, 0, 1, NB, NB);
        send(6000);
        t_valid = 1'b1;
        @(posedge clk_in);
        #1 t_valid = 1'b0;
        wait_done(6);

        // reset in the WAIT of band 1
        push_sample(7000, 6000, 5000, 2, 2, 1);
        send(7000);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_in);
            if (bq_valid_out && band_out == 2'd1) seen = 1'b1;
        end
        chk("band1_issue_seen", 32'(seen), 32'd1);
        @(negedge clk_in);
        #1 rst_in = 1'b0;
        #1;
        chk("mid_rst_ready",   32'(ready_out),        32'd0);
        chk("mid_rst_band",    32'(band_out),         32'd0);
        chk("mid_rst_x_n",     bq_x_n,                32'd0);
        chk("mid_rst_x_n1",    bq_x_n1,               32'd0);
        chk("mid_rst_i_n1",    bq_i_n1,               32'd0);
        chk("mid_rst_y_n1",    bq_y_n1,               32'd0);
        chk("mid_rst_res_y",   result_y_out,          32'd0);
        chk("mid_rst_res_vld", 32'(result_valid_out), 32'd0);
        chk("mid_rst_done",    32'(done_out),         32'd0);
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("post_rst_ready", 32'(ready_out), 32'd1);
        push_sample(8000, 0, 0, 0, NB, NB);
        send(8000);
        wait_done(7);

        repeat (4) @(negedge clk_in);
        chk("iss_queue_empty", 32'(exp_iss.size()), 32'd0);
        chk("res_queue_empty", 32'(exp_res.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
